// File: rtl/seq_tx.sv
// seq_tx: serial frame transmitter, MSB first, with programmable repeats.
// Define SEQ_TX_PARITY_EN to append an even-parity bit to every frame.
module seq_tx #(
   parameter int WIDTH  = 8,
   parameter int REPS_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WIDTH-1:0]  data,
   input  logic [REPS_W-1:0] reps,
   output logic              ready,
   output logic              y,
   output logic              valid,
   output logic              done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GAP
`ifdef SEQ_TX_PARITY_EN
      , S_PAR
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  sh_q, sh_d;
   logic [WIDTH-1:0]  word_q, word_d;
   logic [REPS_W-1:0] rep_q, rep_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              y_q, y_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              frame_end;

`ifdef SEQ_TX_PARITY_EN
   logic par;
   assign par = ^word_q;
`endif

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      word_d    = word_q;
      rep_d     = rep_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      frame_end = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (load) begin
               sh_d    = data;
               word_d  = data;
               rep_d   = reps;
               cnt_d   = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (cnt_q == LAST) begin
`ifdef SEQ_TX_PARITY_EN
               state_d = S_PAR;
`else
               frame_end = 1'b1;
`endif
            end else begin
               sh_d  = {sh_q[WIDTH-2:0], 1'b0};
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef SEQ_TX_PARITY_EN
         S_PAR: frame_end = 1'b1;
`endif
         S_GAP: begin
            // Reload from the captured word; live data is ignored.
            rep_d   = rep_q - 1'b1;
            sh_d    = word_q;
            cnt_d   = '0;
            state_d = S_SEND;
         end
         default: state_d = S_IDLE;
      endcase

      if (frame_end) begin
         if (rep_q != '0) begin
            state_d = S_GAP;
         end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
      end

      ready_d = (state_d == S_IDLE);
      valid_d = (state_d == S_SEND);
      y_d     = (state_d == S_SEND) & sh_d[WIDTH-1];
`ifdef SEQ_TX_PARITY_EN
      if (state_d == S_PAR) begin
         valid_d = 1'b1;
         y_d     = par;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         word_q  <= '0;
         rep_q   <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         y_q     <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         word_q  <= word_d;
         rep_q   <= rep_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign ready = ready_q;
   assign y     = y_q;
   assign valid = valid_q;
   assign done  = done_q;

endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx: directed bench for seq_tx (WIDTH=8, REPS_W=4).
// Parity vectors run only when SEQ_TX_PARITY_EN is defined.
module tb_seq_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       load = 1'b0;
   logic [7:0] data = '0;
   logic [3:0] reps = '0;
   logic       ready, y, valid, done;

   int checks = 0;
   int errors = 0;

`ifdef SEQ_TX_PARITY_EN
   localparam int F = 9;
`else
   localparam int F = 8;
`endif

   seq_tx #(.WIDTH(8), .REPS_W(4)) dut (
      .clk(clk), .reset(reset), .load(load), .data(data),
      .reps(reps), .ready(ready), .y(y), .valid(valid), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse load; on return the bench sits in cycle 1.
   task automatic send(input logic [7:0] d, input logic [3:0] r);
      load = 1'b1;
      data = d;
      reps = r;
      step();
      load = 1'b0;
   endtask

   // Check one frame's bits (and parity bit if built), leaving
   // the bench in the cycle after the frame.
   task automatic chk_frame(input string tag, input logic [7:0] d);
      for (int k = 0; k < 8; k++) begin
         check({tag, "_y"}, int'(y), int'(d[7-k]));
         check({tag, "_v"}, int'(valid), 1);
         check({tag, "_rdy"}, int'(ready), 0);
         step();
      end
`ifdef SEQ_TX_PARITY_EN
      check({tag, "_par"}, int'(y), int'(^d));
      check({tag, "_parv"}, int'(valid), 1);
      step();
`endif
   endtask

   task automatic chk_done(input string tag);
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_drdy"}, int'(ready), 1);
      check({tag, "_dv"}, int'(valid), 0);
      check({tag, "_dy"}, int'(y), 0);
   endtask

   initial begin
      int nv;
      int dc;
      logic [7:0] tmp;

      reset = 1'b0;
      step();
      step();
      check("rst_ready", int'(ready), 1);
      check("rst_y", int'(y), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_done", int'(done), 0);
      reset = 1'b1;
      step();

      // Basic frame
      send(8'hD4, 4'd0);
      chk_frame("d4", 8'hD4);
      chk_done("d4");
      step();
      check("d4_idle_done", int'(done), 0);
      check("d4_idle_y", int'(y), 0);

      // Repeats; live inputs changed after acceptance
      send(8'hA5, 4'd2);
      data = 8'h00;
      reps = 4'd0;
      for (int r = 0; r < 3; r++) begin
         chk_frame("a5", 8'hA5);
         if (r < 2) begin
            check("a5_gap_v", int'(valid), 0);
            check("a5_gap_y", int'(y), 0);
            check("a5_gap_rdy", int'(ready), 0);
            check("a5_gap_done", int'(done), 0);
            step();
         end
      end
      chk_done("a5");
      step();

      // Busy protection: load in cycle 3 is ignored
      send(8'hFF, 4'd0);
      for (int k = 0; k < 8; k++) begin
         check("busy_y", int'(y), 1);
         check("busy_v", int'(valid), 1);
         load = (k == 2);
         data = (k == 2) ? 8'h00 : 8'hFF;
         step();
      end
      load = 1'b0;
`ifdef SEQ_TX_PARITY_EN
      check("busy_par", int'(y), 0);
      step();
`endif
      chk_done("busy");
      step();
      check("busy_nostart_v", int'(valid), 0);
      check("busy_nostart_rdy", int'(ready), 1);

      // Reset mid-frame at cycle 4
      send(8'hFF, 4'd3);
      step();
      step();
      step();
      check("mid_y_c4", int'(y), 1);
      reset = 1'b0;
      step();
      check("mid_y", int'(y), 0);
      check("mid_v", int'(valid), 0);
      check("mid_rdy", int'(ready), 1);
      check("mid_done", int'(done), 0);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check("mid_nodone", int'(done), 0);
         check("mid_idle_v", int'(valid), 0);
      end
      send(8'h3C, 4'd0);
      chk_frame("post", 8'h3C);
      chk_done("post");

      // Reset and load together: reset wins
      reset = 1'b0;
      send(8'hFF, 4'd0);
      reset = 1'b1;
      check("rl_v", int'(valid), 0);
      check("rl_rdy", int'(ready), 1);
      step();
      check("rl_v2", int'(valid), 0);

      // Back-to-back
      send(8'h0F, 4'd0);
      chk_frame("b2b0", 8'h0F);
      chk_done("b2b0");
      load = 1'b1;
      data = 8'h81;
      step();
      load = 1'b0;
      chk_frame("b2b1", 8'h81);
      chk_done("b2b1");
      step();

      // Maximum repeat count: 16 frames
      send(8'hC3, 4'd15);
      nv = 0;
      dc = 0;
      for (int n = 1; n <= 400; n++) begin
         if (done) begin
            dc = n;
            break;
         end
         if (valid) nv++;
         step();
      end
      check("max_done_cycle", dc, 16 * F + 15 + 1);
      check("max_valid_cnt", nv, 16 * F);
      check("max_rdy", int'(ready), 1);
      step();

`ifdef SEQ_TX_PARITY_EN
      tmp = 8'hB5;
      send(tmp, 4'd0);
      for (int k = 0; k < 8; k++) step();
      check("pb5_par", int'(y), 1);
      check("pb5_parv", int'(valid), 1);
      step();
      chk_done("pb5");
      step();
      tmp = 8'hD4;
      send(tmp, 4'd0);
      for (int k = 0; k < 8; k++) step();
      check("pd4_par", int'(y), 0);
      check("pd4_parv", int'(valid), 1);
      step();
      chk_done("pd4");
`else
      tmp = 8'h00;
`endif
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
